// File: rtl/fwd_sel_gen.sv
// Operand-forwarding select generator and load-use stall detector beside the ID/EX register.
// Optional build macro FWD_STAT_EN adds saturating stall/forward statistics counters.
module fwd_sel_gen #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        sel_rs,
    output logic [1:0]        sel_rt,
    output logic [CNT_W-1:0]  stat_stall,
    output logic [CNT_W-1:0]  stat_fwd
);

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] addr;
        logic              is_load;
    } trk_t;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_A  = 2'b10;
    localparam logic [1:0] SEL_B  = 2'b11;

    trk_t       ex_q, ex_d, mem_q, mem_d;
    logic [1:0] sel_rs_q, sel_rs_d, sel_rt_q, sel_rt_d;
    logic       issue;

    // A load in EX cannot feed the next EX cycle, so only non-loads forward from EX.
    function automatic logic [1:0] fwd_code(input logic              used,
                                            input logic [REG_AW-1:0] src,
                                            input trk_t              ex,
                                            input trk_t              mem);
        logic [1:0] code;
        code = SEL_RF;
        if (used && src != '0) begin
            if (ex.valid && ex.wr_en && !ex.is_load && ex.addr == src)
                code = SEL_A;
            else if (mem.valid && mem.wr_en && mem.addr == src)
                code = SEL_B;
        end
        return code;
    endfunction

    // NOTE: stall is decoded from current state and ID inputs with no register, so an
    // asynchronous reset of ex_q removes it in the same cycle.
    always_comb begin
        stall = id_valid && !flush && ex_q.valid && ex_q.is_load && ex_q.wr_en
                && ex_q.addr != '0
                && ((id_use_rs && id_rs == ex_q.addr) || (id_use_rt && id_rt == ex_q.addr));
    end

    always_comb begin
        issue = id_valid && !stall && !flush;
        ex_d  = '0;
        if (issue) begin
            ex_d.valid   = 1'b1;
            ex_d.wr_en   = id_wr_en;
            ex_d.addr    = id_wr_addr;
            ex_d.is_load = id_is_load;
        end
        mem_d    = ex_q;
        sel_rs_d = issue ? fwd_code(id_use_rs, id_rs, ex_q, mem_q) : SEL_RF;
        sel_rt_d = issue ? fwd_code(id_use_rt, id_rt, ex_q, mem_q) : SEL_RF;
    end

    // NOTE: every sequential assignment is non-blocking so all stages update from the
    // same pre-edge values, just like the pipeline registers they model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            sel_rs_q <= SEL_RF;
            sel_rt_q <= SEL_RF;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            sel_rs_q <= sel_rs_d;
            sel_rt_q <= sel_rt_d;
        end
    end

    assign sel_rs = sel_rs_q;
    assign sel_rt = sel_rt_q;

`ifdef FWD_STAT_EN
    logic [CNT_W-1:0] stat_stall_q, stat_stall_d, stat_fwd_q, stat_fwd_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stat_stall_d = stat_stall_q;
        stat_fwd_d   = stat_fwd_q;
        if (stall && stat_stall_q != '1)
            stat_stall_d = stat_stall_q + 1'b1;
        if ((sel_rs_d != SEL_RF || sel_rt_d != SEL_RF) && stat_fwd_q != '1)
            stat_fwd_d = stat_fwd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_q <= '0;
            stat_fwd_q   <= '0;
        end else begin
            stat_stall_q <= stat_stall_d;
            stat_fwd_q   <= stat_fwd_d;
        end
    end

    assign stat_stall = stat_stall_q;
    assign stat_fwd   = stat_fwd_q;
`else
    assign stat_stall = '0;
    assign stat_fwd   = '0;
`endif

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Directed bench for fwd_sel_gen: expected selects are queued at issue and checked one edge later.
// Statistics checks follow FWD_STAT_EN; a 3-bit counter width makes saturation reachable.
module tb_fwd_sel_gen;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wr_en;
    logic [4:0]       id_wr_addr;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic [1:0]       sel_rs;
    logic [1:0]       sel_rt;
    logic [CNT_W-1:0] stat_stall;
    logic [CNT_W-1:0] stat_fwd;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_nstall = 0;
    int exp_nfwd   = 0;
    logic [3:0] exp_q[$];

    fwd_sel_gen #(.REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wr_en   (id_wr_en),
        .id_wr_addr (id_wr_addr),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .sel_rs     (sel_rs),
        .sel_rt     (sel_rt),
        .stat_stall (stat_stall),
        .stat_fwd   (stat_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int x);
        return (x >= CNT_MAX) ? CNT_MAX : x + 1;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [4:0] wa, input logic ld, input logic fl);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wr_en   = we;
        id_wr_addr = wa;
        id_is_load = ld;
        flush      = fl;
    endtask

    // One ID cycle: stall is checked combinationally, the selects after the next edge.
    task automatic step(input string tag, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt,
                        input logic we, input logic [4:0] wa, input logic ld,
                        input logic fl, input logic e_stall, input logic [1:0] e_rs,
                        input logic [1:0] e_rt);
        logic [3:0] exp;
        drive(v, rs, rt, urs, urt, we, wa, ld, fl);
        #1;
        check({tag, "_stall"}, 32'(stall), 32'(e_stall));
        exp_q.push_back({e_rs, e_rt});
        if (e_stall) exp_nstall = sat_inc(exp_nstall);
        if (e_rs != 2'b00 || e_rt != 2'b00) exp_nfwd = sat_inc(exp_nfwd);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_sel_rs"}, 32'(sel_rs), 32'(exp[3:2]));
            check({tag, "_sel_rt"}, 32'(sel_rt), 32'(exp[1:0]));
        end
        @(negedge clk);
    endtask

    task automatic check_stats(input string tag);
`ifdef FWD_STAT_EN
        check({tag, "_stat_stall"}, 32'(stat_stall), 32'(exp_nstall));
        check({tag, "_stat_fwd"}, 32'(stat_fwd), 32'(exp_nfwd));
`else
        check({tag, "_stat_stall"}, 32'(stat_stall), 32'd0);
        check({tag, "_stat_fwd"}, 32'(stat_fwd), 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #3;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_sel_rs", 32'(sel_rs), 32'd0);
        check("rst_sel_rt", 32'(sel_rt), 32'd0);
        check_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;

        //    tag           v  rs  rt  urs urt we wa  ld fl  stall rs     rt
        step("alu_add3",   1, 1,  2,  1,  1,  1, 3,  0, 0,  0, 2'b00, 2'b00);
        step("alu_sub",    1, 3,  6,  1,  1,  1, 4,  0, 0,  0, 2'b10, 2'b00);
        step("nop1",       0, 0,  0,  0,  0,  0, 0,  0, 0,  0, 2'b00, 2'b00);
        step("d2_add3",    1, 1,  2,  1,  1,  1, 3,  0, 0,  0, 2'b00, 2'b00);
        step("nop2",       0, 0,  0,  0,  0,  0, 0,  0, 0,  0, 2'b00, 2'b00);
        step("d2_or",      1, 7,  3,  1,  1,  1, 8,  0, 0,  0, 2'b00, 2'b11);
        step("near_a",     1, 1,  2,  1,  1,  1, 3,  0, 0,  0, 2'b00, 2'b00);
        step("near_b",     1, 1,  2,  1,  1,  1, 3,  0, 0,  0, 2'b00, 2'b00);
        step("near_or",    1, 3,  10, 1,  1,  1, 9,  0, 0,  0, 2'b10, 2'b00);
        step("rs_eq_rt",   1, 9,  9,  1,  1,  1, 11, 0, 0,  0, 2'b10, 2'b10);
        step("lw5",        1, 11, 0,  1,  0,  1, 5,  1, 0,  0, 2'b10, 2'b00);
        step("lu_stall",   1, 5,  1,  1,  1,  1, 6,  0, 0,  1, 2'b00, 2'b00);
        step("lu_resume",  1, 5,  1,  1,  1,  1, 6,  0, 0,  0, 2'b11, 2'b00);
        step("w0",         1, 1,  2,  1,  1,  1, 0,  0, 0,  0, 2'b00, 2'b00);
        step("r0",         1, 0,  0,  1,  1,  1, 12, 0, 0,  0, 2'b00, 2'b00);
        step("fl_lw5",     1, 0,  0,  1,  0,  1, 5,  1, 0,  0, 2'b00, 2'b00);
        step("fl_add",     1, 5,  1,  1,  1,  1, 6,  0, 1,  0, 2'b00, 2'b00);
        step("fl_after",   1, 6,  1,  1,  1,  1, 13, 0, 0,  0, 2'b00, 2'b00);
        check_stats("mid");

        // Repeated load-use pairs push both counters into saturation.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("pair%0d_lw", i),  1, 0, 0, 1, 0, 1, 5,  1, 0, 0, 2'b00, 2'b00);
            step($sformatf("pair%0d_stl", i), 1, 5, 5, 1, 1, 1, 14, 0, 0, 1, 2'b00, 2'b00);
            step($sformatf("pair%0d_add", i), 1, 5, 5, 1, 1, 1, 14, 0, 0, 0, 2'b11, 2'b11);
            check_stats($sformatf("pair%0d", i));
        end

        step("rst_lw",     1, 14, 0,  1,  0,  1, 5,  1, 0,  0, 2'b10, 2'b00);
        drive(1'b1, 5'd5, 5'd14, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        #1;
        check("pre_rst_stall", 32'(stall), 32'd1);
        check("pre_rst_sel_rs", 32'(sel_rs), 32'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_sel_rs", 32'(sel_rs), 32'd0);
        check("mid_rst_sel_rt", 32'(sel_rt), 32'd0);
        exp_nstall = 0;
        exp_nfwd   = 0;
        check_stats("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst",   1, 5,  14, 1,  1,  1, 7,  0, 0,  0, 2'b00, 2'b00);
        check_stats("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
